// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader that writes the core's instruction memory.
// Ports: clk, rst (async high), start, rx_valid/rx_data/rx_ready byte stream,
//   imem_we/imem_addr/imem_wdata memory write port,
//   core_rst, busy, done, err, words_loaded status.
// Optional: IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte and the CSUM state.
module imem_loader #(
  parameter int IMEM_WORDS = 64,
  parameter int AW         = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          imem_we,
  output logic [31:0]   imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          core_rst,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA,
    S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] MAX_N = 17'(IMEM_WORDS);
  localparam logic [AW:0] ONE   = (AW+1)'(1);

  state_t      state_q, state_d;
  logic [7:0]  n_lo_q, n_lo_d;
  logic [AW:0] n_q, n_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] word_q, word_d;
  logic [AW:0] wcnt_q, wcnt_d;
  logic        xfer;
  logic [16:0] n_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_lo_q  <= '0;
      n_q     <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      wcnt_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_lo_q  <= n_lo_d;
      n_q     <= n_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      wcnt_q  <= wcnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    n_lo_d  = n_lo_q;
    n_d     = n_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    wcnt_d  = wcnt_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    rx_ready = state_q inside {S_HDR0, S_HDR1, S_DATA, S_CSUM};
    xfer     = rx_valid & rx_ready;
    n_full   = {1'b0, rx_data, n_lo_q};

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR0;
          bcnt_d  = '0;
          wcnt_d  = '0;
          n_d     = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_HDR0: begin
        if (xfer) begin
          n_lo_d  = rx_data;
          state_d = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          n_d = n_full[AW:0];
          if (n_full == 17'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else if (n_full > MAX_N) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          // first byte of a word ends up in [7:0]
          word_d = {rx_data, word_q[31:8]};
          bcnt_d = 2'(bcnt_q + 2'd1);
          if (bcnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        wcnt_d = wcnt_q + ONE;
        if (wcnt_q == n_q - ONE) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) begin
          if (8'(sum_q + rx_data) == 8'h00) state_d = S_DONE;
          else                              state_d = S_ERR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

`ifdef IMEM_LOADER_CHECKSUM_EN
    // header and payload bytes feed the running sum; the check byte does not
    if (xfer && state_q != S_CSUM) sum_d = 8'(sum_q + rx_data);
`endif
  end

  assign imem_we      = (state_q == S_WRITE);
  assign imem_wdata   = word_q;
  assign imem_addr    = {{(30-AW){1'b0}}, wcnt_q[AW-1:0], 2'b00};
  assign core_rst     = (state_q != S_DONE);
  assign busy         = state_q inside {S_HDR0, S_HDR1, S_DATA, S_WRITE, S_CSUM};
  assign done         = (state_q == S_DONE);
  assign err          = (state_q == S_ERR);
  assign words_loaded = wcnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed sessions plus random programs
// compared against a stream-level model of expected memory writes and status.
module tb_imem_loader;

  localparam int IMEM_WORDS = 64;
  localparam int AW = 6;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk, rst, start, rx_valid, rx_ready;
  logic [7:0]  rx_data;
  logic        imem_we, core_rst, busy, done, err;
  logic [31:0] imem_addr, imem_wdata;
  logic [AW:0] words_loaded;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int fall_cyc = 0;
  logic prev_crst = 1'b1;
  logic [63:0] obs_q[$];

  imem_loader #(.IMEM_WORDS(IMEM_WORDS), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .busy(busy), .done(done), .err(err),
    .words_loaded(words_loaded)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (start === 1'b1) start_cyc <= cyc;
    if (imem_we === 1'b1) begin
      obs_q.push_back({imem_addr, imem_wdata});
      check("rx_ready_in_write", {63'd0, rx_ready}, 64'd0);
    end
  end

  always @(negedge clk) begin
    prev_crst <= core_rst;
    if (prev_crst === 1'b1 && core_rst === 1'b0) fall_cyc <= cyc - 1;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flags"},
          {58'd0, core_rst, rx_ready, imem_we, busy, done, err},
          64'b100000);
    check({tag, "_addr"}, {32'd0, imem_addr}, 64'd0);
    check({tag, "_wdata"}, {32'd0, imem_wdata}, 64'd0);
    check({tag, "_wl"}, {57'd0, words_loaded}, 64'd0);
  endtask

  function automatic void build(input logic [31:0] w[$], input int n,
                                input bit bad, output logic [7:0] b[$]);
    logic [7:0] s;
    logic [31:0] x;
    b.delete();
    b.push_back(n[7:0]);
    b.push_back(n[15:8]);
    foreach (w[i]) begin
      x = w[i];
      for (int k = 0; k < 4; k++) b.push_back(x[8*k +: 8]);
    end
    s = 8'd0;
    foreach (b[i]) s = 8'(s + b[i]);
    if (CS == 1 && n <= IMEM_WORDS) b.push_back(8'(8'd0 - s) ^ {7'd0, bad});
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1;
    @(posedge clk);
  endtask

  task automatic send(input string tag, input logic [7:0] b[$], input int gap);
    int i, t;
    i = 0;
    t = 0;
    while (i < b.size() && t < 2000) begin
      @(negedge clk);
      start = 0;
      if ($urandom_range(99) < gap) rx_valid = 0;
      else begin
        rx_valid = 1;
        rx_data  = b[i];
      end
      @(posedge clk);
      t++;
      if (rx_valid && rx_ready) i++;
    end
    check({tag, "_bytes_sent"}, 64'(i), 64'(b.size()));
    @(negedge clk);
    rx_valid = 0;
    start = 0;
  endtask

  task automatic load(input string tag, input logic [31:0] w[$], input int n,
                      input int gap, input bit bad, input bit ok);
    logic [7:0] b[$];
    int nw, k;
    build(w, n, bad, b);
    obs_q.delete();
    pulse_start();
    send(tag, b, gap);
    k = 0;
    while (busy !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    nw = (n > IMEM_WORDS) ? 0 : w.size();
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, {63'd0, ok});
    check({tag, "_err"}, {63'd0, err}, {63'd0, !ok});
    check({tag, "_core_rst"}, {63'd0, core_rst}, {63'd0, !ok});
    check({tag, "_rx_ready"}, {63'd0, rx_ready}, 64'd0);
    check({tag, "_wl"}, {57'd0, words_loaded}, 64'(nw));
    check({tag, "_nwrites"}, 64'(obs_q.size()), 64'(nw));
    for (int i = 0; i < nw && i < obs_q.size(); i++)
      check($sformatf("%s_write%0d", tag, i), obs_q[i], {32'(i * 4), w[i]});
    if (ok && gap == 0)
      check({tag, "_latency"}, 64'(fall_cyc - start_cyc), 64'(2 + 5 * n + CS));
  endtask

  initial begin
    logic [31:0] w[$];
    logic [7:0] b[$];
    int n;

    rst = 1;
    start = 0;
    rx_valid = 1;
    rx_data = 8'hA5;
    repeat (2) @(negedge clk);
    check_reset_outputs("in_reset");
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_reset_outputs("idle_hold");
    end
    rx_valid = 0;

    w = '{32'h00100513, 32'h00200593};
    load("spec2", w, 2, 0, 0, 1);
    load("spec2_gaps", w, 2, 40, 0, 1);

    w.delete();
    load("n0", w, 0, 20, 0, 1);

    load("ovf", w, IMEM_WORDS + 1, 0, 0, 0);
    w = '{32'h00000013};
    load("after_err", w, 1, 0, 0, 1);

    for (int t = 0; t < 4; t++) begin
      w.delete();
      n = $urandom_range(1, 6);
      repeat (n) w.push_back($urandom);
      load($sformatf("rand%0d", t), w, n, 30, 0, 1);
    end

    w.delete();
    repeat (IMEM_WORDS) w.push_back($urandom);
    load("full", w, IMEM_WORDS, 10, 0, 1);

    w.delete();
    repeat (4) w.push_back($urandom);
    build(w, 4, 0, b);
    b = b[0:9];
    obs_q.delete();
    pulse_start();
    send("mid", b, 0);
    repeat (2) @(negedge clk);
    check("mid_writes", 64'(obs_q.size()), 64'd2);
    rst = 1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check_reset_outputs("after_rst");
    load("reload", w, 4, 25, 0, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    w = '{32'h00000013};
    load("csum_bad", w, 1, 0, 1, 0);
    load("csum_ok", w, 1, 0, 0, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
